// File: rtl/entrada_time_multidigito_pkg.sv
// -----------------------------------------------------------------------------
// entrada_time_multidigito_pkg
// Shared definitions for the multi-digit keypad entry block:
//   KEY_W         - number of keypad lines (keys 0..9)
//   BCD_W         - width of one BCD digit
//   entry_state_t - entry FSM state encoding
//   key_encode()  - priority encoder, highest pressed key index wins
// -----------------------------------------------------------------------------
package entrada_time_multidigito_pkg;

  localparam int KEY_W = 10;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_LOAD         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } entry_state_t;

  // Scanning upward and overwriting leaves the highest set index as the result.
  // An all-zero keypad yields 0; callers qualify with |keys.
  function automatic logic [BCD_W-1:0] key_encode(input logic [KEY_W-1:0] keys);
    logic [BCD_W-1:0] code_v;
    code_v = 4'd0;
    for (int k = 0; k < KEY_W; k++) begin
      if (keys[k]) begin
        code_v = 4'(k);
      end else begin
        code_v = code_v;
      end
    end
    return code_v;
  endfunction

endpackage

// File: rtl/entrada_time_multidigito_if.sv
// -----------------------------------------------------------------------------
// entrada_time_multidigito_if
// Groups the keypad-side inputs and the entry-register outputs.
//   enablen, clear, keypad            : driven by the master (keypad/controller)
//   D, loadn, digits, digit_count,
//   full, pgt_1Hz                     : driven by the slave (entry block)
// Parameter NUM_DIGITS must match the entry block it is connected to.
// -----------------------------------------------------------------------------
interface entrada_time_multidigito_if #(
  parameter int NUM_DIGITS = 4
) ();
  import entrada_time_multidigito_pkg::*;

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                        enablen;
  logic                        clear;
  logic [KEY_W-1:0]            keypad;
  logic [BCD_W-1:0]            D;
  logic                        loadn;
  logic [BCD_W*NUM_DIGITS-1:0] digits;
  logic [CNT_W-1:0]            digit_count;
  logic                        full;
  logic                        pgt_1Hz;

  modport master (
    output enablen, clear, keypad,
    input  D, loadn, digits, digit_count, full, pgt_1Hz
  );

  modport slave (
    input  enablen, clear, keypad,
    output D, loadn, digits, digit_count, full, pgt_1Hz
  );

endinterface

// File: rtl/entrada_time_multidigito_divisor.sv
// -----------------------------------------------------------------------------
// divisor_freq
// Free-running divider producing a one-cycle tick every CLK_DIV clk cycles.
//   clk  : system clock
//   rst  : asynchronous active-high reset (counter and tick cleared)
//   tick : registered, high only while the counter equals CLK_DIV-1
// -----------------------------------------------------------------------------
module divisor_freq #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_r;
  logic [CW-1:0] div_cnt_s;
  logic          tick_r;
  logic          tick_s;

  // Next count and tick; tick is derived from the next count so the registered
  // tick lines up with the cycle in which the counter holds CLK_DIV-1.
  always_comb begin
    div_cnt_s = div_cnt_r;
    if (div_cnt_r == LAST) begin
      div_cnt_s = {CW{1'b0}};
    end else begin
      div_cnt_s = div_cnt_r + CW'(1);
    end
    tick_s = (div_cnt_s == LAST);
  end

  // Divider counter and tick register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {CW{1'b0}};
      tick_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_s;
      tick_r    <= tick_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/entrada_time_multidigito.sv
// -----------------------------------------------------------------------------
// entrada_time_multidigito
// Debounced multi-digit BCD keypad entry with a free-running 1 Hz-style tick.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of entrada_time_multidigito_if
//          in : enablen (active-low), clear (sync), keypad[9:0]
//          out: D, loadn (active-low strobe), digits (newest in [3:0]),
//               digit_count (saturating), full, pgt_1Hz
// A key must be seen stable for DEBOUNCE_CYCLES edges before it is shifted
// into the digit register; a held key loads exactly once.
// -----------------------------------------------------------------------------
module entrada_time_multidigito
  import entrada_time_multidigito_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLK_DIV         = 100
) (
  input  logic                           clk,
  input  logic                           rst,
  entrada_time_multidigito_if.slave      bus
);

  localparam int               DIG_W      = BCD_W * NUM_DIGITS;
  localparam int               CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(NUM_DIGITS);
  // Count value at which the next matching sample reaches DEBOUNCE_CYCLES.
  localparam logic [7:0]       DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  // With a single-sample debounce the first sighting already qualifies.
  localparam bit               DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

  entry_state_t     state_r;
  entry_state_t     state_s;
  logic [BCD_W-1:0] cap_r;
  logic [BCD_W-1:0] cap_s;
  logic [7:0]       deb_cnt_r;
  logic [7:0]       deb_cnt_s;
  logic             key_valid_s;
  logic [BCD_W-1:0] key_code_s;
  logic             load_s;

  logic [BCD_W-1:0] d_r;
  logic [BCD_W-1:0] d_s;
  logic             loadn_r;
  logic             loadn_s;
  logic [DIG_W-1:0] digits_r;
  logic [DIG_W-1:0] digits_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             full_r;
  logic             full_s;
  logic             tick_s;

  // Key decode shared by the FSM.
  always_comb begin
    key_valid_s = |bus.keypad;
    key_code_s  = key_encode(bus.keypad);
  end

  // Entry FSM next-state logic. clear and enablen both abort whatever is in
  // progress; load_s is only raised from LOAD when neither is active, which
  // is what makes clear win over a simultaneous load.
  always_comb begin
    state_s   = state_r;
    cap_s     = cap_r;
    deb_cnt_s = deb_cnt_r;
    load_s    = 1'b0;
    if (bus.clear || bus.enablen) begin
      state_s   = ST_IDLE;
      deb_cnt_s = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (key_valid_s) begin
            cap_s     = key_code_s;
            deb_cnt_s = 8'd1;
            state_s   = DEB_SINGLE ? ST_LOAD : ST_DEBOUNCE;
          end else begin
            state_s   = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (!key_valid_s || (key_code_s != cap_r)) begin
            state_s   = ST_IDLE;
            deb_cnt_s = 8'd0;
          end else if (deb_cnt_r == DEB_LAST) begin
            state_s   = ST_LOAD;
            deb_cnt_s = deb_cnt_r + 8'd1;
          end else begin
            deb_cnt_s = deb_cnt_r + 8'd1;
          end
        end
        ST_LOAD: begin
          load_s  = 1'b1;
          state_s = ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (!key_valid_s) begin
            state_s   = ST_IDLE;
            deb_cnt_s = 8'd0;
          end else begin
            state_s   = ST_WAIT_RELEASE;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          deb_cnt_s = 8'd0;
        end
      endcase
    end
  end

  // Entry FSM state, captured key and debounce counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cap_r     <= 4'd0;
      deb_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      cap_r     <= cap_s;
      deb_cnt_r <= deb_cnt_s;
    end
  end

  // Output register next values: clear zeroes the digit register, a load
  // shifts the captured digit in at the bottom (oldest digit falls off the top).
  always_comb begin
    d_s      = d_r;
    loadn_s  = 1'b1;
    digits_s = digits_r;
    count_s  = count_r;
    full_s   = full_r;
    if (bus.clear) begin
      digits_s = {DIG_W{1'b0}};
      count_s  = {CNT_W{1'b0}};
      full_s   = 1'b0;
    end else if (load_s) begin
      loadn_s              = 1'b0;
      d_s                  = cap_r;
      digits_s             = digits_r << BCD_W;
      digits_s[BCD_W-1:0]  = cap_r;
      if (count_r != FULL_CNT) begin
        count_s = count_r + CNT_W'(1);
      end else begin
        count_s = count_r;
      end
      full_s = (count_s == FULL_CNT);
    end else begin
      loadn_s = 1'b1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r      <= 4'd0;
      loadn_r  <= 1'b1;
      digits_r <= {DIG_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      d_r      <= d_s;
      loadn_r  <= loadn_s;
      digits_r <= digits_s;
      count_r  <= count_s;
      full_r   <= full_s;
    end
  end

  divisor_freq #(
    .CLK_DIV (CLK_DIV)
  ) u_divisor_freq (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign bus.D           = d_r;
  assign bus.loadn       = loadn_r;
  assign bus.digits      = digits_r;
  assign bus.digit_count = count_r;
  assign bus.full        = full_r;
  assign bus.pgt_1Hz     = tick_s;

endmodule

// File: tb/tb_entrada_time_multidigito.sv
// -----------------------------------------------------------------------------
// tb_entrada_time_multidigito
// Self-checking bench: NUM_DIGITS=4, DEBOUNCE_CYCLES=3, CLK_DIV=10.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_entrada_time_multidigito;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  entrada_time_multidigito_if #(.NUM_DIGITS(4)) bus ();

  entrada_time_multidigito #(
    .NUM_DIGITS      (4),
    .DEBOUNCE_CYCLES (3),
    .CLK_DIV         (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  kp;
    logic        en;
    logic        clr;
    int          hold;
    int          gap;
    int          exp_pulses;
    int          exp_lat;
    logic [3:0]  exp_d;
    logic [15:0] exp_digits;
    logic [2:0]  exp_cnt;
    logic        exp_full;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Apply one table record: optional clear, hold the key, release, then compare.
  task automatic run_vec(input int idx);
    vec_t v;
    int   pulses;
    int   lat;
    string tag;
    v      = vecs[idx];
    pulses = 0;
    lat    = -1;
    tag    = $sformatf("v%0d", idx);
    if (v.clr) begin
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
    end
    for (int i = 0; i < v.hold; i++) begin
      bus.keypad  = v.kp;
      bus.enablen = v.en;
      @(negedge clk);
      if (bus.loadn == 1'b0) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    for (int i = 0; i < v.gap; i++) begin
      bus.keypad  = 10'd0;
      bus.enablen = 1'b0;
      @(negedge clk);
      if (bus.loadn == 1'b0) pulses++;
    end
    check({tag, "_pulses"}, 32'(pulses), 32'(v.exp_pulses));
    if (v.exp_pulses > 0) check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_D"},      {28'd0, bus.D},           {28'd0, v.exp_d});
    check({tag, "_digits"}, {16'd0, bus.digits},      {16'd0, v.exp_digits});
    check({tag, "_count"},  {29'd0, bus.digit_count}, {29'd0, v.exp_cnt});
    check({tag, "_full"},   {31'd0, bus.full},        {31'd0, v.exp_full});
  endtask

  initial begin
    int pulses;
    int lat;
    int first_tick;

    //                kp       en    clr   hold gap pul lat D     digits    cnt   full
    vecs[0] = '{10'h020, 1'b0, 1'b0, 20, 3, 1, 3, 4'd5, 16'h0005, 3'd1, 1'b0};
    vecs[1] = '{10'h002, 1'b0, 1'b1,  6, 3, 1, 3, 4'd1, 16'h0001, 3'd1, 1'b0};
    vecs[2] = '{10'h004, 1'b0, 1'b0,  6, 3, 1, 3, 4'd2, 16'h0012, 3'd2, 1'b0};
    vecs[3] = '{10'h008, 1'b0, 1'b0,  6, 3, 1, 3, 4'd3, 16'h0123, 3'd3, 1'b0};
    vecs[4] = '{10'h010, 1'b0, 1'b0,  6, 3, 1, 3, 4'd4, 16'h1234, 3'd4, 1'b1};
    vecs[5] = '{10'h080, 1'b0, 1'b0,  6, 3, 1, 3, 4'd7, 16'h2347, 3'd4, 1'b1};
    vecs[6] = '{10'h201, 1'b0, 1'b0,  6, 3, 1, 3, 4'd9, 16'h3479, 3'd4, 1'b1};
    vecs[7] = '{10'h040, 1'b0, 1'b0,  2, 3, 0, 0, 4'd9, 16'h3479, 3'd4, 1'b1};
    vecs[8] = '{10'h100, 1'b1, 1'b0, 10, 3, 0, 0, 4'd9, 16'h3479, 3'd4, 1'b1};
    vecs[9] = '{10'h040, 1'b0, 1'b0,  8, 3, 1, 3, 4'd6, 16'h0006, 3'd1, 1'b0};

    rst         = 1'b0;
    bus.keypad  = 10'd0;
    bus.enablen = 1'b0;
    bus.clear   = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    check("rst_D",      {28'd0, bus.D},           32'd0);
    check("rst_loadn",  {31'd0, bus.loadn},       32'd1);
    check("rst_digits", {16'd0, bus.digits},      32'd0);
    check("rst_count",  {29'd0, bus.digit_count}, 32'd0);
    check("rst_full",   {31'd0, bus.full},        32'd0);
    check("rst_pgt",    {31'd0, bus.pgt_1Hz},     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Divider phase from reset release: tick at cycles 9, 19, 29.
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check($sformatf("pgt_c%0d", k), {31'd0, bus.pgt_1Hz}, {31'd0, ((k % 10) == 9)});
    end

    for (int i = 0; i <= 8; i++) run_vec(i);

    // Clear on the LOAD edge: key 3, clear raised just before the load edge.
    pulses = 0;
    bus.keypad = 10'h008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.loadn == 1'b0) pulses++;
    end
    bus.clear  = 1'b1;
    bus.keypad = 10'd0;
    @(negedge clk);
    check("clr_load_loadn",  {31'd0, bus.loadn},       32'd1);
    check("clr_load_digits", {16'd0, bus.digits},      32'd0);
    check("clr_load_count",  {29'd0, bus.digit_count}, 32'd0);
    check("clr_load_full",   {31'd0, bus.full},        32'd0);
    check("clr_load_D",      {28'd0, bus.D},           32'd9);
    bus.clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.loadn == 1'b0) pulses++;
    end
    check("clr_load_pulses", 32'(pulses), 32'd0);

    run_vec(9);

    // Reset in the middle of a debounce, key kept held through and after it.
    pulses = 0;
    bus.keypad = 10'h020;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.loadn == 1'b0) pulses++;
    end
    rst = 1'b1;
    #1;
    check("midrst_digits", {16'd0, bus.digits},      32'd0);
    check("midrst_count",  {29'd0, bus.digit_count}, 32'd0);
    @(negedge clk);
    if (bus.loadn == 1'b0) pulses++;
    check("midrst_pre_pulses", 32'(pulses), 32'd0);
    rst        = 1'b0;
    pulses     = 0;
    lat        = -1;
    first_tick = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.loadn == 1'b0) begin
        pulses++;
        if (lat < 0) lat = i;
      end
      if (bus.pgt_1Hz && first_tick < 0) first_tick = i;
    end
    check("midrst_pulses",     32'(pulses),     32'd1);
    check("midrst_latency",    32'(lat),        32'd3);
    check("midrst_first_tick", 32'(first_tick), 32'd8);
    check("midrst_D",          {28'd0, bus.D},           32'd5);
    check("midrst_digits2",    {16'd0, bus.digits},      32'h0005);
    check("midrst_count2",     {29'd0, bus.digit_count}, 32'd1);
    bus.keypad = 10'd0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
